// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and default frame parameters.
// Used by both the SPI master and the SPI target.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int         SPI_WIDTH       = 8;
  localparam logic [7:0] SPI_IDLE_BYTE   = 8'hFF;
  localparam int         SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronized level and one delay flop.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clock_in,
  input  logic reset,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic [STAGES-1:0] sync_next;
  logic              prev_reg;

  // Each stage takes the previous stage; stage 0 takes the raw pin.
  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        assign sync_next[gi] = din;
      end else begin : g_rest
        assign sync_next[gi] = sync_reg[gi-1];
      end
    end
  endgenerate

  // Synchronizer chain plus one delay flop for edge detection.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= sync_next;
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign rise = sync_reg[STAGES-1] & ~prev_reg;
  assign fall = ~sync_reg[STAGES-1] & prev_reg;

endmodule

// File: rtl/spi_target.sv
// SPI target port, mode 0, MSB first, full duplex with multi-byte bursts.
// The CPU loads a TX byte into a holding register and unloads RX bytes;
// the external master's sclk/mosi/ssn are synchronized into clock_in.
module spi_target
  import spi_pkg::*;
#(
  parameter int               WIDTH       = SPI_WIDTH,
  parameter logic [WIDTH-1:0] IDLE_BYTE   = WIDTH'(SPI_IDLE_BYTE),
  parameter int               SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             load,
  input  logic             unload,
  input  logic [WIDTH-1:0] datain,
  output logic [WIDTH-1:0] dataout,
  output logic             rx_valid,
  output logic             tx_full,
  output logic             overrun,
  output logic             busy,
  input  logic             sclk_in,
  input  logic             mosi_in,
  input  logic             ssn_in,
  output logic             miso,
  output logic             miso_oe
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic sclk_rise;
  logic sclk_fall;
  logic ssn_rise;
  logic ssn_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .din      (sclk_in),
    .rise     (sclk_rise),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ssn_sync (
    .clock_in (clock_in),
    .reset    (reset),
    .din      (ssn_in),
    .rise     (ssn_rise),
    .fall     (ssn_fall)
  );

  // mosi goes through the same depth as sclk so it lines up with sclk_rise.
  logic [SYNC_STAGES-1:0] mosi_sync_reg;
  logic [SYNC_STAGES-1:0] mosi_sync_next;
  logic                   mosi_s;

  generate
    for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_mosi
      if (gi == 0) begin : g_first
        assign mosi_sync_next[gi] = mosi_in;
      end else begin : g_rest
        assign mosi_sync_next[gi] = mosi_sync_reg[gi-1];
      end
    end
  endgenerate

  // Plain synchronizer chain for mosi.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      mosi_sync_reg <= '0;
    end else begin
      mosi_sync_reg <= mosi_sync_next;
    end
  end

  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  state_t           state_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-2:0] rx_shift_reg;
  logic [WIDTH-1:0] tx_hold_reg;

  logic             in_frame;
  logic             reload_now;
  logic             frame_done;
  logic [WIDTH-1:0] reload_byte;
  logic [WIDTH-1:0] rx_word;

  // ssn deselect takes priority over any sclk edge in the same cycle.
  assign in_frame    = (state_reg == ACTIVE) && !ssn_rise;
  assign reload_now  = ((state_reg == IDLE) && ssn_fall) ||
                       (in_frame && sclk_fall && (bit_cnt_reg == '0));
  assign frame_done  = in_frame && sclk_rise && (bit_cnt_reg == CW'(WIDTH-1));
  assign reload_byte = tx_full ? tx_hold_reg : IDLE_BYTE;
  assign rx_word     = {rx_shift_reg, mosi_s};

  // FSM, shifters, TX holding register and status flags.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      rx_shift_reg <= '0;
      tx_hold_reg  <= '0;
      tx_full      <= 1'b0;
      dataout      <= '0;
      rx_valid     <= 1'b0;
      overrun      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // A reload empties the holding register; a simultaneous load refills it.
      if (reload_now) begin
        tx_full <= load;
        if (load) begin
          tx_hold_reg <= datain;
        end
      end else if (load && !tx_full) begin
        tx_hold_reg <= datain;
        tx_full     <= 1'b1;
      end

      // Completion wins over unload: the new byte stays marked unread.
      if (frame_done) begin
        dataout  <= rx_word;
        rx_valid <= 1'b1;
        if (rx_valid && !unload) begin
          overrun <= 1'b1;
        end
      end else if (unload) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (ssn_fall) begin
            state_reg   <= ACTIVE;
            busy        <= 1'b1;
            shift_reg   <= reload_byte;
            bit_cnt_reg <= '0;
          end
        end
        ACTIVE: begin
          if (ssn_rise) begin
            state_reg   <= IDLE;
            busy        <= 1'b0;
            bit_cnt_reg <= '0;
          end else if (sclk_rise) begin
            rx_shift_reg <= rx_word[WIDTH-2:0];
            if (bit_cnt_reg == CW'(WIDTH-1)) begin
              bit_cnt_reg <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CW'(1);
            end
          end else if (sclk_fall) begin
            if (bit_cnt_reg != '0) begin
              shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
            end else begin
              shift_reg <= reload_byte;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign miso    = busy & shift_reg[WIDTH-1];
  assign miso_oe = busy;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: the bench acts as SPI master (sclk = clock_in/10)
// and compares against a byte-level model of the target's CPU interface.
module tb_spi_target;

  logic       clock_in = 1'b0;
  logic       reset    = 1'b1;
  logic       load     = 1'b0;
  logic       unload   = 1'b0;
  logic [7:0] datain   = 8'h00;
  logic [7:0] dataout;
  logic       rx_valid;
  logic       tx_full;
  logic       overrun;
  logic       busy;
  logic       sclk_in  = 1'b0;
  logic       mosi_in  = 1'b0;
  logic       ssn_in   = 1'b1;
  logic       miso;
  logic       miso_oe;

  always #5 clock_in = ~clock_in;

  spi_target dut (
    .clock_in (clock_in),
    .reset    (reset),
    .load     (load),
    .unload   (unload),
    .datain   (datain),
    .dataout  (dataout),
    .rx_valid (rx_valid),
    .tx_full  (tx_full),
    .overrun  (overrun),
    .busy     (busy),
    .sclk_in  (sclk_in),
    .mosi_in  (mosi_in),
    .ssn_in   (ssn_in),
    .miso     (miso),
    .miso_oe  (miso_oe)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the CPU-visible state.
  logic [7:0] m_dataout  = 8'h00;
  bit         m_rx_valid = 1'b0;
  bit         m_overrun  = 1'b0;
  bit         m_tx_full  = 1'b0;
  logic [7:0] m_tx_val   = 8'h00;

  logic [7:0] mosi_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  // Frame start: the pending TX byte (or the idle byte) goes out next.
  function automatic logic [7:0] m_reload();
    logic [7:0] v;
    v = m_tx_full ? m_tx_val : 8'hFF;
    m_tx_full = 1'b0;
    return v;
  endfunction

  function automatic void m_complete(input logic [7:0] b);
    if (m_rx_valid) m_overrun = 1'b1;
    m_rx_valid = 1'b1;
    m_dataout  = b;
  endfunction

  task automatic pulse_load(input logic [7:0] v);
    load   = 1'b1;
    datain = v;
    wait_clk(1);
    load   = 1'b0;
    if (!m_tx_full) begin
      m_tx_full = 1'b1;
      m_tx_val  = v;
    end
  endtask

  task automatic pulse_unload();
    unload = 1'b1;
    wait_clk(1);
    unload = 1'b0;
    m_rx_valid = 1'b0;
    m_overrun  = 1'b0;
  endtask

  // One mode-0 bit: set mosi, sample miso just before the rising edge.
  task automatic do_bit(input logic b, output logic m, input bit mid_load, input logic [7:0] v);
    mosi_in = b;
    wait_clk(5);
    m = miso;
    sclk_in = 1'b1;
    wait_clk(2);
    if (mid_load) pulse_load(v);
    else wait_clk(1);
    wait_clk(2);
    sclk_in = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_dataout"}, 32'(dataout), 32'(m_dataout));
    check({name, "_rx_valid"}, 32'(rx_valid), 32'(m_rx_valid));
    check({name, "_overrun"}, 32'(overrun), 32'(m_overrun));
    check({name, "_tx_full"}, 32'(tx_full), 32'(m_tx_full));
    check({name, "_busy"}, 32'(busy), 32'd0);
    check({name, "_miso_oe"}, 32'(miso_oe), 32'd0);
    check({name, "_miso"}, 32'(miso), 32'd0);
  endtask

  // Full burst of mosi_q bytes; optional abort after abort_rises rising edges.
  task automatic send_burst(input int abort_rises, input bit mid_en, input logic [7:0] mid_v,
                            input string name);
    logic [7:0] exp_b;
    logic [7:0] got_b;
    logic       m;
    int         rises;
    bit         aborted;
    rises   = 0;
    aborted = 1'b0;
    got_b   = 8'h00;
    ssn_in  = 1'b0;
    wait_clk(6);
    check({name, "_busy_sel"}, 32'(busy), 32'd1);
    check({name, "_oe_sel"}, 32'(miso_oe), 32'd1);
    exp_b = m_reload();
    for (int i = 0; i < mosi_q.size(); i++) begin
      for (int j = 7; j >= 0; j--) begin
        do_bit(mosi_q[i][j], m, mid_en && (i == 0) && (j == 3), mid_v);
        got_b[j] = m;
        rises++;
        if (abort_rises != 0 && rises == abort_rises) begin
          aborted = 1'b1;
          break;
        end
      end
      if (aborted) break;
      check($sformatf("%s_miso_byte%0d", name, i), 32'(got_b), 32'(exp_b));
      m_complete(mosi_q[i]);
      exp_b = m_reload();
    end
    wait_clk(5);
    ssn_in = 1'b1;
    wait_clk(6);
    check_idle_outputs(name);
    $display("[TB] %s: %0d byte(s) abort=%0d dataout=%02h rx_valid=%0b overrun=%0b tx_full=%0b",
             name, mosi_q.size(), abort_rises, dataout, rx_valid, overrun, tx_full);
  endtask

  initial begin
    logic       m;
    logic [7:0] r;
    int         nb;
    int         ab;

    // Reset state
    wait_clk(3);
    check("rst_dataout", 32'(dataout), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_full", 32'(tx_full), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_miso_oe", 32'(miso_oe), 32'd0);
    reset = 1'b0;
    wait_clk(6);

    // 1: loaded byte goes out while 3C is captured
    pulse_load(8'hA5);
    check("t1_tx_full_loaded", 32'(tx_full), 32'd1);
    mosi_q = '{8'h3C};
    send_burst(0, 1'b0, 8'h00, "t1");

    // 2: nothing loaded -> idle byte
    mosi_q = '{8'h00};
    send_burst(0, 1'b0, 8'h00, "t2");

    // 3: 2-byte burst, second TX byte loaded during byte 1
    pulse_unload();
    pulse_load(8'h11);
    pulse_load(8'h99);   // ignored: holding register already full
    mosi_q = '{8'h5A, 8'hC3};
    send_burst(0, 1'b1, 8'h22, "t3");

    // 4: two frames without unload -> overrun, then unload clears both flags
    pulse_unload();
    mosi_q = '{8'h12};
    send_burst(0, 1'b0, 8'h00, "t4a");
    mosi_q = '{8'h34};
    send_burst(0, 1'b0, 8'h00, "t4b");
    pulse_unload();
    wait_clk(1);
    check("t4_unload_rx_valid", 32'(rx_valid), 32'(m_rx_valid));
    check("t4_unload_overrun", 32'(overrun), 32'(m_overrun));

    // 5: abort after 5 rising edges, then a clean frame
    mosi_q = '{8'hF0};
    send_burst(5, 1'b0, 8'h00, "t5_abort");
    mosi_q = '{8'h81};
    send_burst(0, 1'b0, 8'h00, "t5_next");

    // 6: reset mid-frame, then a frame shifts the idle byte
    pulse_load(8'h5A);
    ssn_in = 1'b0;
    wait_clk(6);
    do_bit(1'b1, m, 1'b0, 8'h00);
    do_bit(1'b0, m, 1'b1, 8'h77);
    do_bit(1'b1, m, 1'b0, 8'h00);
    reset = 1'b1;
    wait_clk(1);
    reset = 1'b0;
    m_dataout  = 8'h00;
    m_rx_valid = 1'b0;
    m_overrun  = 1'b0;
    m_tx_full  = 1'b0;
    wait_clk(1);
    check_idle_outputs("t6_reset");
    ssn_in = 1'b1;
    wait_clk(6);
    mosi_q = '{8'h6E};
    send_burst(0, 1'b0, 8'h00, "t6_after");

    // Randomized bursts
    for (int k = 0; k < 25; k++) begin
      if ($urandom_range(1, 0) != 0) pulse_load(8'($urandom));
      if ($urandom_range(3, 0) == 0) pulse_load(8'($urandom));
      nb = int'($urandom_range(3, 1));
      mosi_q.delete();
      for (int i = 0; i < nb; i++) mosi_q.push_back(8'($urandom));
      ab = 0;
      if ($urandom_range(5, 0) == 0) begin
        ab = int'($urandom_range(8 * nb - 1, 1));
        if (ab % 8 == 0) ab = ab - 1;
      end
      r = 8'($urandom);
      send_burst(ab, $urandom_range(1, 0) != 0, r, $sformatf("rnd%0d", k));
      if ($urandom_range(1, 0) != 0) pulse_unload();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
